// File: rtl/xge_tx_pkg.sv
// Shared definitions for the XGE TX enqueue path.
// Provides the FIFO status bit positions, the enqueue FSM state type,
// and the all-clear status value.
package xge_tx_pkg;

    // Enqueue FSM states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PKT   = 2'd1,
        ST_ABORT = 2'd2,
        ST_DROP  = 2'd3
    } xge_tx_state_e;

    // Status word is {ERR, EOP, SOP, MOD[MOD_W-1:0]}
    function automatic int TXSTATUS_SOP(input int mod_w);
        return mod_w;
    endfunction

    function automatic int TXSTATUS_EOP(input int mod_w);
        return mod_w + 1;
    endfunction

    function automatic int TXSTATUS_ERR(input int mod_w);
        return mod_w + 2;
    endfunction

    // No flags set, modulus zero
    localparam int TXSTATUS_NONE = 0;

endpackage

// File: rtl/xge_sat_counter.sv
// Saturating up-counter used for the TX packet/drop statistics.
// Sticks at all-ones; clear has priority over increment.
module xge_sat_counter #(
    parameter int W = 32
) (
    input  logic         clk_156m25,
    input  logic         reset_156m25_n,
    input  logic         inc,
    input  logic         clear,
    output logic [W-1:0] count
);

    logic [W-1:0] r_count;

    // Count events, holding at the maximum value
    always_ff @(posedge clk_156m25 or negedge reset_156m25_n) begin
        if (!reset_156m25_n) begin
            r_count <= '0;
        end else if (clear) begin
            r_count <= '0;
        end else if (inc && (r_count != '1)) begin
            r_count <= r_count + W'(1);
        end
    end

    assign count = r_count;

endmodule

// File: rtl/xge_tx_enqueue_p.sv
// XGE MAC TX enqueue stage: client packet interface to TX data FIFO.
// Registers FIFO writes, checks framing, tail-drops whole packets on
// overflow (writing an EOP|ERR abort marker when a packet is cut short),
// and keeps saturating packet/drop counters.
// Optional build macro: XGE_TX_BYTE_SWAP_EN reverses byte order of the
// client data (big-endian client); default build passes data unchanged.
module xge_tx_enqueue_p #(
    parameter int DATA_W = 64,
    parameter int MOD_W  = $clog2(DATA_W/8),
    parameter int STAT_W = MOD_W + 3,
    parameter int CNT_W  = 32
) (
    input  logic              clk_156m25,
    input  logic              reset_156m25_n,
    input  logic [DATA_W-1:0] pkt_tx_data,
    input  logic              pkt_tx_val,
    input  logic              pkt_tx_sop,
    input  logic              pkt_tx_eop,
    input  logic [MOD_W-1:0]  pkt_tx_mod,
    output logic              pkt_tx_full,
    output logic [DATA_W-1:0] txdfifo_wdata,
    output logic [STAT_W-1:0] txdfifo_wstatus,
    output logic              txdfifo_wen,
    input  logic              txdfifo_wfull,
    input  logic              txdfifo_walmost_full,
    output logic              status_txdfifo_ovflow_tog,
    output logic              status_tx_framing_err_tog,
    output logic [CNT_W-1:0]  stat_pkt_cnt,
    output logic [CNT_W-1:0]  stat_drop_cnt
);

    import xge_tx_pkg::*;

    localparam int SOP_B = TXSTATUS_SOP(MOD_W);
    localparam int EOP_B = TXSTATUS_EOP(MOD_W);
    localparam int ERR_B = TXSTATUS_ERR(MOD_W);

    xge_tx_state_e       r_state;
    xge_tx_state_e       w_state_nxt;
    logic                r_eop_seen;
    logic                w_eop_seen_nxt;

    logic [DATA_W-1:0]   w_din_p0;
    logic [DATA_W-1:0]   w_wdata_p0;
    logic [STAT_W-1:0]   w_wstatus_p0;
    logic                w_wen_p0;
    logic                w_marker_p0;

    logic                w_ovf;
    logic                w_frm;
    logic                w_pkt_inc;
    logic                w_drop_inc;

    logic [DATA_W-1:0]   r_wdata_p1;
    logic [STAT_W-1:0]   r_wstatus_p1;
    logic                r_wen_p1;
    logic                r_ovf_tog;
    logic                r_frm_tog;

`ifdef XGE_TX_BYTE_SWAP_EN
    localparam int NBYTES = DATA_W / 8;

    function automatic logic [DATA_W-1:0] byte_swap(input logic [DATA_W-1:0] d);
        logic [DATA_W-1:0] s;
        s = '0;
        for (int i = 0; i < NBYTES; i++) begin
            s[8*i +: 8] = d[8*(NBYTES-1-i) +: 8];
        end
        return s;
    endfunction

    assign w_din_p0 = byte_swap(pkt_tx_data);
`else
    assign w_din_p0 = pkt_tx_data;
`endif

    // Backpressure is a straight pass-through of the FIFO almost-full flag
    assign pkt_tx_full = txdfifo_walmost_full;

    // ---- stage p0: framing FSM decides write, status flags and events ----

    // Next-state, write decision and event strobes for the current beat
    always_comb begin
        w_state_nxt    = r_state;
        w_eop_seen_nxt = r_eop_seen;
        w_wen_p0       = 1'b0;
        w_marker_p0    = 1'b0;
        w_wstatus_p0   = STAT_W'(TXSTATUS_NONE);
        w_ovf          = 1'b0;
        w_frm          = 1'b0;
        w_pkt_inc      = 1'b0;
        w_drop_inc     = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (pkt_tx_val) begin
                    if (!pkt_tx_sop) begin
                        // Data outside a packet is discarded
                        w_frm = 1'b1;
                    end else if (txdfifo_wfull) begin
                        // No room for the first beat: drop the whole packet
                        w_ovf       = 1'b1;
                        w_drop_inc  = 1'b1;
                        w_state_nxt = pkt_tx_eop ? ST_IDLE : ST_DROP;
                    end else begin
                        w_wen_p0            = 1'b1;
                        w_wstatus_p0[SOP_B] = 1'b1;
                        if (pkt_tx_eop) begin
                            w_wstatus_p0[EOP_B]       = 1'b1;
                            w_wstatus_p0[MOD_W-1:0]   = pkt_tx_mod;
                            w_pkt_inc                 = 1'b1;
                            w_state_nxt               = ST_IDLE;
                        end else begin
                            w_state_nxt = ST_PKT;
                        end
                    end
                end
            end

            ST_PKT: begin
                if (pkt_tx_val) begin
                    if (txdfifo_wfull) begin
                        // Beat lost mid-packet: close the packet with a marker later
                        w_ovf          = 1'b1;
                        w_eop_seen_nxt = pkt_tx_eop;
                        w_state_nxt    = ST_ABORT;
                    end else if (pkt_tx_sop) begin
                        // Missing EOP: terminate the old packet on this beat, drop the new one
                        w_frm               = 1'b1;
                        w_wen_p0            = 1'b1;
                        w_wstatus_p0[EOP_B] = 1'b1;
                        w_wstatus_p0[ERR_B] = 1'b1;
                        w_drop_inc          = 1'b1;
                        w_state_nxt         = pkt_tx_eop ? ST_IDLE : ST_DROP;
                    end else begin
                        w_wen_p0 = 1'b1;
                        if (pkt_tx_eop) begin
                            w_wstatus_p0[EOP_B]     = 1'b1;
                            w_wstatus_p0[MOD_W-1:0] = pkt_tx_mod;
                            w_pkt_inc               = 1'b1;
                            w_state_nxt             = ST_IDLE;
                        end
                    end
                end
            end

            ST_ABORT: begin
                // Incoming beats are discarded; only their EOP is remembered
                w_eop_seen_nxt = r_eop_seen | (pkt_tx_val & pkt_tx_eop);
                if (!txdfifo_wfull) begin
                    w_wen_p0            = 1'b1;
                    w_marker_p0         = 1'b1;
                    w_wstatus_p0[EOP_B] = 1'b1;
                    w_wstatus_p0[ERR_B] = 1'b1;
                    w_drop_inc          = 1'b1;
                    w_state_nxt         = w_eop_seen_nxt ? ST_IDLE : ST_DROP;
                end
            end

            ST_DROP: begin
                if (pkt_tx_val) begin
                    if (pkt_tx_sop) begin
                        w_frm = 1'b1;
                    end
                    if (pkt_tx_eop) begin
                        w_state_nxt = ST_IDLE;
                    end
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Abort marker carries all-zero data
    assign w_wdata_p0 = w_marker_p0 ? '0 : w_din_p0;

    // FSM state and the EOP-seen flag used while aborting
    always_ff @(posedge clk_156m25 or negedge reset_156m25_n) begin
        if (!reset_156m25_n) begin
            r_state    <= ST_IDLE;
            r_eop_seen <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_eop_seen <= w_eop_seen_nxt;
        end
    end

    // ---- stage p1: registered FIFO write port ----

    // Register the FIFO write; data/status hold while no write is issued
    always_ff @(posedge clk_156m25 or negedge reset_156m25_n) begin
        if (!reset_156m25_n) begin
            r_wen_p1     <= 1'b0;
            r_wdata_p1   <= '0;
            r_wstatus_p1 <= '0;
        end else begin
            r_wen_p1 <= w_wen_p0;
            if (w_wen_p0) begin
                r_wdata_p1   <= w_wdata_p0;
                r_wstatus_p1 <= w_wstatus_p0;
            end
        end
    end

    // Event toggles, flipping at most once per cycle
    always_ff @(posedge clk_156m25 or negedge reset_156m25_n) begin
        if (!reset_156m25_n) begin
            r_ovf_tog <= 1'b0;
            r_frm_tog <= 1'b0;
        end else begin
            r_ovf_tog <= r_ovf_tog ^ w_ovf;
            r_frm_tog <= r_frm_tog ^ w_frm;
        end
    end

    assign txdfifo_wen               = r_wen_p1;
    assign txdfifo_wdata             = r_wdata_p1;
    assign txdfifo_wstatus           = r_wstatus_p1;
    assign status_txdfifo_ovflow_tog = r_ovf_tog;
    assign status_tx_framing_err_tog = r_frm_tog;

    xge_sat_counter #(.W(CNT_W)) u_pkt_cnt (
        .clk_156m25     (clk_156m25),
        .reset_156m25_n (reset_156m25_n),
        .inc            (w_pkt_inc),
        .clear          (1'b0),
        .count          (stat_pkt_cnt)
    );

    xge_sat_counter #(.W(CNT_W)) u_drop_cnt (
        .clk_156m25     (clk_156m25),
        .reset_156m25_n (reset_156m25_n),
        .inc            (w_drop_inc),
        .clear          (1'b0),
        .count          (stat_drop_cnt)
    );

endmodule

// File: tb/tb_xge_tx_enqueue_p.sv
// Testbench for xge_tx_enqueue_p: directed scenarios plus a randomized run
// checked against a packet-level reference model. Counters are built
// 4 bits wide here so saturation is reachable.
module tb_xge_tx_enqueue_p;

    localparam int DATA_W = 64;
    localparam int MOD_W  = 3;
    localparam int STAT_W = MOD_W + 3;
    localparam int CNT_W  = 4;
    localparam int CMAX   = (1 << CNT_W) - 1;

    localparam logic [STAT_W-1:0] S_SOP = STAT_W'(1 << MOD_W);
    localparam logic [STAT_W-1:0] S_EOP = STAT_W'(1 << (MOD_W+1));
    localparam logic [STAT_W-1:0] S_ERR = STAT_W'(1 << (MOD_W+2));

    logic              clk_156m25 = 1'b0;
    logic              reset_156m25_n = 1'b0;
    logic [DATA_W-1:0] pkt_tx_data = '0;
    logic              pkt_tx_val = 1'b0;
    logic              pkt_tx_sop = 1'b0;
    logic              pkt_tx_eop = 1'b0;
    logic [MOD_W-1:0]  pkt_tx_mod = '0;
    logic              pkt_tx_full;
    logic [DATA_W-1:0] txdfifo_wdata;
    logic [STAT_W-1:0] txdfifo_wstatus;
    logic              txdfifo_wen;
    logic              txdfifo_wfull = 1'b0;
    logic              txdfifo_walmost_full = 1'b0;
    logic              status_txdfifo_ovflow_tog;
    logic              status_tx_framing_err_tog;
    logic [CNT_W-1:0]  stat_pkt_cnt;
    logic [CNT_W-1:0]  stat_drop_cnt;

    int checks = 0;
    int errors = 0;

    xge_tx_enqueue_p #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk_156m25                (clk_156m25),
        .reset_156m25_n            (reset_156m25_n),
        .pkt_tx_data               (pkt_tx_data),
        .pkt_tx_val                (pkt_tx_val),
        .pkt_tx_sop                (pkt_tx_sop),
        .pkt_tx_eop                (pkt_tx_eop),
        .pkt_tx_mod                (pkt_tx_mod),
        .pkt_tx_full               (pkt_tx_full),
        .txdfifo_wdata             (txdfifo_wdata),
        .txdfifo_wstatus           (txdfifo_wstatus),
        .txdfifo_wen               (txdfifo_wen),
        .txdfifo_wfull             (txdfifo_wfull),
        .txdfifo_walmost_full      (txdfifo_walmost_full),
        .status_txdfifo_ovflow_tog (status_txdfifo_ovflow_tog),
        .status_tx_framing_err_tog (status_tx_framing_err_tog),
        .stat_pkt_cnt              (stat_pkt_cnt),
        .stat_drop_cnt             (stat_drop_cnt)
    );

    always #5 clk_156m25 = ~clk_156m25;

    // ---------------- reference model (packet-level) ----------------
    bit                m_in_pkt, m_marker_pending, m_discarding, m_eop_seen;
    bit                exp_wen;
    logic [DATA_W-1:0] exp_wdata;
    logic [STAT_W-1:0] exp_wstatus;
    int                exp_pkt, exp_drop;
    bit                exp_ovf, exp_frm;

    function automatic logic [DATA_W-1:0] client_to_fifo(input logic [DATA_W-1:0] d);
        logic [DATA_W-1:0] r;
`ifdef XGE_TX_BYTE_SWAP_EN
        r = {<<8{d}};
`else
        r = d;
`endif
        return r;
    endfunction

    function automatic void model_reset();
        m_in_pkt = 0; m_marker_pending = 0; m_discarding = 0; m_eop_seen = 0;
        exp_wen = 0; exp_wdata = '0; exp_wstatus = '0;
        exp_pkt = 0; exp_drop = 0; exp_ovf = 0; exp_frm = 0;
    endfunction

    function automatic void emit(input logic [DATA_W-1:0] d, input logic [STAT_W-1:0] s);
        exp_wen = 1; exp_wdata = d; exp_wstatus = s;
    endfunction

    function automatic void model_step(input bit v, input bit s, input bit e,
                                       input logic [MOD_W-1:0] m,
                                       input logic [DATA_W-1:0] d, input bit wf);
        logic [STAT_W-1:0] tail;
        tail = e ? (S_EOP | STAT_W'(m)) : '0;
        exp_wen = 0;
        if (m_marker_pending) begin
            if (v && e) m_eop_seen = 1;
            if (!wf) begin
                emit('0, S_EOP | S_ERR);
                if (exp_drop < CMAX) exp_drop++;
                m_marker_pending = 0;
                m_discarding = !m_eop_seen;
            end
        end else if (m_discarding) begin
            if (v) begin
                if (s) exp_frm = !exp_frm;
                if (e) m_discarding = 0;
            end
        end else if (m_in_pkt) begin
            if (v) begin
                if (wf) begin
                    exp_ovf = !exp_ovf; m_marker_pending = 1; m_eop_seen = e; m_in_pkt = 0;
                end else if (s) begin
                    exp_frm = !exp_frm;
                    emit(client_to_fifo(d), S_EOP | S_ERR);
                    if (exp_drop < CMAX) exp_drop++;
                    m_in_pkt = 0; m_discarding = !e;
                end else begin
                    emit(client_to_fifo(d), tail);
                    if (e) begin
                        if (exp_pkt < CMAX) exp_pkt++;
                        m_in_pkt = 0;
                    end
                end
            end
        end else if (v) begin
            if (!s) exp_frm = !exp_frm;
            else if (wf) begin
                exp_ovf = !exp_ovf;
                if (exp_drop < CMAX) exp_drop++;
                m_discarding = !e;
            end else begin
                emit(client_to_fifo(d), S_SOP | tail);
                if (e) begin
                    if (exp_pkt < CMAX) exp_pkt++;
                end else m_in_pkt = 1;
            end
        end
    endfunction

    // Drive one cycle of inputs, advance the model, sample 1 ns after the edge
    task automatic tick(input bit v, input bit s, input bit e, input logic [MOD_W-1:0] m,
                        input logic [DATA_W-1:0] d, input bit wf);
        pkt_tx_val = v; pkt_tx_sop = s; pkt_tx_eop = e; pkt_tx_mod = m;
        pkt_tx_data = d; txdfifo_wfull = wf;
        model_step(v, s, e, m, d, wf);
        @(posedge clk_156m25);
        #1;
    endtask

    task automatic do_reset();
        pkt_tx_val = 0; pkt_tx_sop = 0; pkt_tx_eop = 0; pkt_tx_mod = '0;
        pkt_tx_data = '0; txdfifo_wfull = 0; txdfifo_walmost_full = 0;
        reset_156m25_n = 0;
        repeat (2) @(posedge clk_156m25);
        #1;
        reset_156m25_n = 1;
        model_reset();
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        do_reset();
        checks++; if (txdfifo_wen !== 1'b0) begin errors++; $display("FAIL reset_wen got %0b want 0", txdfifo_wen); end
        checks++; if (txdfifo_wdata !== '0) begin errors++; $display("FAIL reset_wdata got %h want 0", txdfifo_wdata); end
        checks++; if (txdfifo_wstatus !== '0) begin errors++; $display("FAIL reset_wstatus got %h want 0", txdfifo_wstatus); end
        checks++; if (stat_pkt_cnt !== '0 || stat_drop_cnt !== '0) begin errors++; $display("FAIL reset_cnt got %0d/%0d want 0/0", stat_pkt_cnt, stat_drop_cnt); end
        checks++; if (status_txdfifo_ovflow_tog !== 1'b0 || status_tx_framing_err_tog !== 1'b0) begin errors++; $display("FAIL reset_tog got %0b%0b want 00", status_txdfifo_ovflow_tog, status_tx_framing_err_tog); end
    endtask

    task automatic test_three_beat();
        logic [DATA_W-1:0] d2;
        do_reset();
        d2 = 64'hA5A5_0000_1234_5678;
        tick(1, 1, 0, 3'd0, 64'h1111_2222_3333_4444, 0);
        checks++; if (txdfifo_wen !== 1'b1 || txdfifo_wstatus !== S_SOP) begin errors++; $display("FAIL b3_beat1 got wen=%0b st=%h want 1/%h", txdfifo_wen, txdfifo_wstatus, S_SOP); end
        tick(1, 0, 0, 3'd0, 64'h5555_6666_7777_8888, 0);
        checks++; if (txdfifo_wen !== 1'b1 || txdfifo_wstatus !== '0) begin errors++; $display("FAIL b3_beat2 got wen=%0b st=%h want 1/0", txdfifo_wen, txdfifo_wstatus); end
        tick(1, 0, 1, 3'd5, d2, 0);
        checks++; if (txdfifo_wen !== 1'b1 || txdfifo_wstatus !== (S_EOP | 6'd5)) begin errors++; $display("FAIL b3_beat3 got wen=%0b st=%h want 1/%h", txdfifo_wen, txdfifo_wstatus, S_EOP | 6'd5); end
        checks++; if (txdfifo_wdata !== client_to_fifo(d2)) begin errors++; $display("FAIL b3_data got %h want %h", txdfifo_wdata, client_to_fifo(d2)); end
        tick(0, 0, 0, 3'd0, '0, 0);
        checks++; if (txdfifo_wen !== 1'b0) begin errors++; $display("FAIL b3_idle got wen=%0b want 0", txdfifo_wen); end
        checks++; if (stat_pkt_cnt !== 4'd1 || stat_drop_cnt !== 4'd0) begin errors++; $display("FAIL b3_cnt got %0d/%0d want 1/0", stat_pkt_cnt, stat_drop_cnt); end
        checks++; if (status_txdfifo_ovflow_tog !== 1'b0 || status_tx_framing_err_tog !== 1'b0) begin errors++; $display("FAIL b3_tog got %0b%0b want 00", status_txdfifo_ovflow_tog, status_tx_framing_err_tog); end
    endtask

    task automatic test_single_beat();
        do_reset();
        tick(1, 1, 1, 3'd0, 64'hDEAD_BEEF_0000_0001, 0);
        checks++; if (txdfifo_wen !== 1'b1 || txdfifo_wstatus !== (S_SOP | S_EOP)) begin errors++; $display("FAIL sb_write got wen=%0b st=%h want 1/%h", txdfifo_wen, txdfifo_wstatus, S_SOP | S_EOP); end
        tick(1, 1, 1, 3'd2, 64'hDEAD_BEEF_0000_0002, 0);
        checks++; if (txdfifo_wen !== 1'b1 || txdfifo_wstatus !== (S_SOP | S_EOP | 6'd2)) begin errors++; $display("FAIL sb_second got wen=%0b st=%h want 1/%h", txdfifo_wen, txdfifo_wstatus, S_SOP | S_EOP | 6'd2); end
        tick(0, 0, 0, 3'd0, '0, 0);
        checks++; if (stat_pkt_cnt !== 4'd2 || status_tx_framing_err_tog !== 1'b0) begin errors++; $display("FAIL sb_cnt got pkt=%0d frm=%0b want 2/0", stat_pkt_cnt, status_tx_framing_err_tog); end
    endtask

    task automatic test_overflow_mid();
        do_reset();
        tick(1, 1, 0, 3'd0, 64'h0101_0101_0101_0101, 0);
        checks++; if (txdfifo_wen !== 1'b1 || txdfifo_wstatus !== S_SOP) begin errors++; $display("FAIL ovm_beat1 got wen=%0b st=%h want 1/%h", txdfifo_wen, txdfifo_wstatus, S_SOP); end
        tick(1, 0, 0, 3'd0, 64'h0202_0202_0202_0202, 1);
        checks++; if (txdfifo_wen !== 1'b0 || status_txdfifo_ovflow_tog !== 1'b1) begin errors++; $display("FAIL ovm_beat2 got wen=%0b ovf=%0b want 0/1", txdfifo_wen, status_txdfifo_ovflow_tog); end
        tick(1, 0, 0, 3'd0, 64'h0303_0303_0303_0303, 0);
        checks++; if (txdfifo_wen !== 1'b1 || txdfifo_wdata !== '0 || txdfifo_wstatus !== (S_EOP | S_ERR)) begin errors++; $display("FAIL ovm_marker got wen=%0b d=%h st=%h want 1/0/%h", txdfifo_wen, txdfifo_wdata, txdfifo_wstatus, S_EOP | S_ERR); end
        tick(1, 0, 1, 3'd1, 64'h0404_0404_0404_0404, 0);
        checks++; if (txdfifo_wen !== 1'b0 || stat_drop_cnt !== 4'd1 || stat_pkt_cnt !== 4'd0) begin errors++; $display("FAIL ovm_beat4 got wen=%0b drop=%0d pkt=%0d want 0/1/0", txdfifo_wen, stat_drop_cnt, stat_pkt_cnt); end
        tick(1, 1, 1, 3'd0, 64'h0505_0505_0505_0505, 0);
        checks++; if (txdfifo_wen !== 1'b1 || txdfifo_wstatus !== (S_SOP | S_EOP) || txdfifo_wdata !== client_to_fifo(64'h0505_0505_0505_0505)) begin errors++; $display("FAIL ovm_next got wen=%0b st=%h d=%h", txdfifo_wen, txdfifo_wstatus, txdfifo_wdata); end
        checks++; if (status_txdfifo_ovflow_tog !== 1'b1 || stat_pkt_cnt !== 4'd1) begin errors++; $display("FAIL ovm_final got ovf=%0b pkt=%0d want 1/1", status_txdfifo_ovflow_tog, stat_pkt_cnt); end
    endtask

    task automatic test_sop_wfull();
        do_reset();
        tick(1, 1, 0, 3'd0, 64'h1, 1);
        tick(1, 0, 0, 3'd0, 64'h2, 0);
        checks++; if (txdfifo_wen !== 1'b0) begin errors++; $display("FAIL sw_drop_b2 got wen=%0b want 0", txdfifo_wen); end
        tick(1, 0, 1, 3'd0, 64'h3, 0);
        checks++; if (txdfifo_wen !== 1'b0 || stat_drop_cnt !== 4'd1 || status_txdfifo_ovflow_tog !== 1'b1) begin errors++; $display("FAIL sw_drop got wen=%0b drop=%0d ovf=%0b want 0/1/1", txdfifo_wen, stat_drop_cnt, status_txdfifo_ovflow_tog); end
        tick(1, 1, 1, 3'd4, 64'h4, 0);
        checks++; if (txdfifo_wen !== 1'b1 || txdfifo_wstatus !== (S_SOP | S_EOP | 6'd4)) begin errors++; $display("FAIL sw_next got wen=%0b st=%h", txdfifo_wen, txdfifo_wstatus); end
        checks++; if (stat_pkt_cnt !== 4'd1 || status_tx_framing_err_tog !== 1'b0) begin errors++; $display("FAIL sw_cnt got pkt=%0d frm=%0b want 1/0", stat_pkt_cnt, status_tx_framing_err_tog); end
    endtask

    task automatic test_framing();
        logic [DATA_W-1:0] dm;
        do_reset();
        dm = 64'hCAFE_F00D_0BAD_BEEF;
        tick(1, 0, 0, 3'd0, 64'h9, 0);
        checks++; if (txdfifo_wen !== 1'b0 || status_tx_framing_err_tog !== 1'b1) begin errors++; $display("FAIL fr_stray got wen=%0b frm=%0b want 0/1", txdfifo_wen, status_tx_framing_err_tog); end
        tick(1, 1, 0, 3'd0, 64'hA, 0);
        tick(1, 1, 0, 3'd0, dm, 0);
        checks++; if (txdfifo_wen !== 1'b1 || txdfifo_wstatus !== (S_EOP | S_ERR) || txdfifo_wdata !== client_to_fifo(dm)) begin errors++; $display("FAIL fr_midsop got wen=%0b st=%h d=%h", txdfifo_wen, txdfifo_wstatus, txdfifo_wdata); end
        checks++; if (status_tx_framing_err_tog !== 1'b0 || stat_drop_cnt !== 4'd1) begin errors++; $display("FAIL fr_tog got frm=%0b drop=%0d want 0/1", status_tx_framing_err_tog, stat_drop_cnt); end
        tick(1, 0, 1, 3'd0, 64'hB, 0);
        checks++; if (txdfifo_wen !== 1'b0) begin errors++; $display("FAIL fr_dropped got wen=%0b want 0", txdfifo_wen); end
        tick(1, 1, 1, 3'd0, 64'hC, 0);
        checks++; if (txdfifo_wen !== 1'b1 || stat_pkt_cnt !== 4'd1) begin errors++; $display("FAIL fr_recover got wen=%0b pkt=%0d want 1/1", txdfifo_wen, stat_pkt_cnt); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        tick(1, 1, 0, 3'd0, 64'hFFFF_0000_FFFF_0000, 0);
        checks++; if (txdfifo_wen !== 1'b1 || txdfifo_wdata === '0) begin errors++; $display("FAIL rm_pre got wen=%0b d=%h", txdfifo_wen, txdfifo_wdata); end
        #2;
        reset_156m25_n = 0;
        #1;
        checks++; if (txdfifo_wen !== 1'b0 || txdfifo_wdata !== '0 || txdfifo_wstatus !== '0) begin errors++; $display("FAIL rm_async got wen=%0b d=%h st=%h want 0/0/0", txdfifo_wen, txdfifo_wdata, txdfifo_wstatus); end
        @(posedge clk_156m25);
        #1;
        reset_156m25_n = 1;
        model_reset();
        tick(1, 0, 0, 3'd0, 64'h7, 0);
        checks++; if (txdfifo_wen !== 1'b0 || status_tx_framing_err_tog !== 1'b1) begin errors++; $display("FAIL rm_after got wen=%0b frm=%0b want 0/1", txdfifo_wen, status_tx_framing_err_tog); end
    endtask

    task automatic test_byte_order();
        logic [DATA_W-1:0] want;
        do_reset();
`ifdef XGE_TX_BYTE_SWAP_EN
        want = 64'h0001_0203_0405_0607;
`else
        want = 64'h0706_0504_0302_0100;
`endif
        tick(1, 1, 1, 3'd0, 64'h0706_0504_0302_0100, 0);
        checks++; if (txdfifo_wdata !== want) begin errors++; $display("FAIL byte_order got %h want %h", txdfifo_wdata, want); end
    endtask

    task automatic test_saturation();
        do_reset();
        for (int i = 0; i < CMAX + 3; i++) tick(1, 1, 1, 3'd0, 64'(i), 0);
        checks++; if (stat_pkt_cnt !== 4'(CMAX)) begin errors++; $display("FAIL sat_pkt got %0d want %0d", stat_pkt_cnt, CMAX); end
        for (int i = 0; i < CMAX + 3; i++) tick(1, 1, 1, 3'd0, 64'(i), 1);
        checks++; if (stat_drop_cnt !== 4'(CMAX) || stat_pkt_cnt !== 4'(CMAX)) begin errors++; $display("FAIL sat_drop got %0d/%0d want %0d/%0d", stat_drop_cnt, stat_pkt_cnt, CMAX, CMAX); end
    endtask

    task automatic test_random();
        bit v, s, e, wf;
        logic [MOD_W-1:0]  m;
        logic [DATA_W-1:0] d;
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            v  = ($urandom_range(0, 9) < 8);
            s  = ($urandom_range(0, 4) == 0);
            e  = ($urandom_range(0, 3) == 0);
            wf = ($urandom_range(0, 6) == 0);
            m  = MOD_W'($urandom);
            d  = {$urandom, $urandom};
            txdfifo_walmost_full = $urandom_range(0, 1);
            #0;
            checks++; if (pkt_tx_full !== txdfifo_walmost_full) begin errors++; $display("FAIL rnd_full c=%0d got %0b want %0b", c, pkt_tx_full, txdfifo_walmost_full); end
            tick(v, s, e, m, d, wf);
            checks++; if (txdfifo_wen !== exp_wen) begin errors++; $display("FAIL rnd_wen c=%0d got %0b want %0b", c, txdfifo_wen, exp_wen); end
            if (exp_wen) begin
                checks++; if (txdfifo_wdata !== exp_wdata || txdfifo_wstatus !== exp_wstatus) begin errors++; $display("FAIL rnd_write c=%0d got %h/%h want %h/%h", c, txdfifo_wdata, txdfifo_wstatus, exp_wdata, exp_wstatus); end
            end
            checks++; if (stat_pkt_cnt !== 4'(exp_pkt) || stat_drop_cnt !== 4'(exp_drop)) begin errors++; $display("FAIL rnd_cnt c=%0d got %0d/%0d want %0d/%0d", c, stat_pkt_cnt, stat_drop_cnt, exp_pkt, exp_drop); end
            checks++; if (status_txdfifo_ovflow_tog !== exp_ovf || status_tx_framing_err_tog !== exp_frm) begin errors++; $display("FAIL rnd_tog c=%0d got %0b%0b want %0b%0b", c, status_txdfifo_ovflow_tog, status_tx_framing_err_tog, exp_ovf, exp_frm); end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_three_beat();
        test_single_beat();
        test_overflow_mid();
        test_sop_wfull();
        test_framing();
        test_reset_mid();
        test_byte_order();
        test_saturation();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
